// File: rtl/dff_pipe_if.sv
// Valid/ready handshake bundle for the elastic register pipeline.
// The master side supplies words and downstream ready. The slave side is the pipeline.
interface dff_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dff_pipe_reg.sv
// Elastic DEPTH-stage register pipeline with valid/ready flow control and collapsing bubbles.
// Optional per-stage parity with error injection when DFF_PIPE_PARITY_EN is defined.
module dff_pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    dff_pipe_if.slave                    bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DFF_PIPE_PARITY_EN
    ,
    input  logic                         err_inject,
    output logic                         par_err
`endif
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
`ifdef DFF_PIPE_PARITY_EN
    logic [DEPTH-1:0] stage_p;
`endif

    // Ready ripples back combinationally, so an empty stage anywhere lets the tail advance.
    assign adv[DEPTH-1] = ~stage_v[DEPTH-1] | bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_adv
            assign adv[gi] = ~stage_v[gi] | adv[gi+1];
        end
    endgenerate

    assign bus.in_ready = adv[0] & ~flush;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = stage_v[DEPTH-1] & bus.out_ready;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             v_in;
            logic [WIDTH-1:0] d_in;
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            if (gi == 0) begin : g_head
                assign v_in = in_xfer;
                assign d_in = bus.in_data;
            end else begin : g_body
                assign v_in = stage_v[gi-1];
                assign d_in = stage_d[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (adv[gi]) begin
                    valid_reg <= v_in;
                end
            end

            // Data only moves with a valid word, so empty stages keep stale data and stay quiet.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= RESET_VAL;
                end else if (adv[gi] & v_in & ~flush) begin
                    data_reg <= d_in;
                end
            end

            assign stage_v[gi] = valid_reg;
            assign stage_d[gi] = data_reg;

`ifdef DFF_PIPE_PARITY_EN
            logic p_in;
            logic par_reg;

            if (gi == 0) begin : g_phead
                assign p_in = (^bus.in_data) ^ err_inject;
            end else begin : g_pbody
                assign p_in = stage_p[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    par_reg <= 1'b0;
                end else if (adv[gi] & v_in & ~flush) begin
                    par_reg <= p_in;
                end
            end

            assign stage_p[gi] = par_reg;
`endif
        end
    endgenerate

    always_comb begin
        occ_next = occ_reg + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        if (flush) begin
            occ_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign bus.out_valid = stage_v[DEPTH-1];
    assign bus.out_data  = stage_d[DEPTH-1];
    assign occupancy     = occ_reg;

`ifdef DFF_PIPE_PARITY_EN
    assign par_err = stage_v[DEPTH-1] & ((^stage_d[DEPTH-1]) != stage_p[DEPTH-1]);
`endif
endmodule

// File: tb/tb_dff_pipe_reg.sv
// Directed and randomized bench for dff_pipe_reg, checked against a word-position queue model.
// Parity checks are compiled in with DFF_PIPE_PARITY_EN.
module tb_dff_pipe_reg;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] occupancy;
    logic       err_inject = 1'b0;
`ifdef DFF_PIPE_PARITY_EN
    logic       par_err;
`endif

    dff_pipe_if #(.WIDTH(WIDTH)) bus ();

    dff_pipe_reg #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
`ifdef DFF_PIPE_PARITY_EN
        ,
        .err_inject(err_inject),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Each in-flight word is tracked by its stage position; the head is the oldest word.
    typedef struct {
        logic [7:0] d;
        int         pos;
        logic       inj;
    } word_t;

    word_t      q[$];
    logic [7:0] last_out = RV;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_in_ready(input logic ordy, input logic fl);
        return !fl && !(q.size() == DEPTH && !ordy);
    endfunction

    function automatic logic exp_out_valid();
        return q.size() > 0 && q[0].pos == DEPTH - 1;
    endfunction

    task automatic check_outputs();
        check("in_ready", 32'(bus.in_ready), 32'(exp_in_ready(bus.out_ready, flush)));
        check("out_valid", 32'(bus.out_valid), 32'(exp_out_valid()));
        check("out_data", 32'(bus.out_data), 32'(last_out));
        check("occupancy", 32'(occupancy), 32'(q.size()));
`ifdef DFF_PIPE_PARITY_EN
        check("par_err", 32'(par_err), 32'(exp_out_valid() && q[0].inj));
`endif
    endtask

    task automatic model_edge(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic fl, input logic inj);
        logic  ir;
        int    limit;
        word_t w;
        ir = exp_in_ready(ordy, fl);
        if (fl) begin
            q.delete();
            return;
        end
        if (exp_out_valid() && ordy) void'(q.pop_front());
        // A word moves one slot unless the word ahead of it still occupies that slot.
        limit = DEPTH - 1;
        for (int k = 0; k < q.size(); k++) begin
            w = q[k];
            if (w.pos < limit) begin
                w.pos++;
                if (w.pos == DEPTH - 1) last_out = w.d;
            end
            q[k]  = w;
            limit = w.pos - 1;
        end
        if (iv && ir) begin
            w.d = d; w.pos = 0; w.inj = inj;
            q.push_back(w);
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic fl, input logic inj, output logic acc);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        err_inject    = inj;
        #1;
        check_outputs();
        acc = iv && exp_in_ready(ordy, fl);
        @(posedge clk);
        model_edge(iv, d, ordy, fl, inj);
        #1;
    endtask

    initial begin
        logic       acc;
        logic [7:0] d;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-word latency
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Back-to-back streaming
        d = 8'h01;
        for (int i = 0; i < 40 && d <= 8'h10; i++) begin
            step(1'b1, d, 1'b1, 1'b0, 1'b0, acc);
            if (acc) d++;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure, then drain
        d = 8'h01;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, d, 1'b0, 1'b0, 1'b0, acc);
            if (acc) d++;
        end
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        // Flush with three words inside and a word offered
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

`ifdef DFF_PIPE_PARITY_EN
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
`endif

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), acc);
        end

        // Asynchronous reset with three words in flight
        for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0, acc);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        last_out = RV;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
